// File: rtl/med_dispense_ctrl_pkg.sv
// Shared definitions for the medicine dispense path: channel count, index
// width, controller state encoding and the index-to-onehot helper that the
// schedule decoder also uses.
package med_dispense_ctrl_pkg;

  localparam int NUM_MED = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  function automatic logic [NUM_MED-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MED-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/med_dispense_ctrl_arbiter.sv
// Dose request capture and arbitration: rising-edge detection on the request
// strobes, a sticky pending register and a lowest-index-first grant.
// The consumer pulses grant_clr to retire the currently granted index; a
// fresh edge on that same index in the same cycle keeps it pending.
module med_req_arbiter
  import med_dispense_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MED-1:0] med_req,
  input  logic               grant_clr,
  output logic [NUM_MED-1:0] pending,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [NUM_MED-1:0] req_prev_reg;
  logic [NUM_MED-1:0] pending_reg;
  logic [NUM_MED-1:0] pending_next;
  logic [NUM_MED-1:0] req_rise;
  logic [NUM_MED-1:0] clr_mask;

  assign req_rise = med_req & ~req_prev_reg;

  // Per-channel pending update: clear for the retired grant, then OR in new edges so set wins.
  for (genvar gi = 0; gi < NUM_MED; gi++) begin : g_pend
    assign clr_mask[gi]     = grant_clr && (grant_idx == IDX_W'(gi));
    assign pending_next[gi] = (pending_reg[gi] & ~clr_mask[gi]) | req_rise[gi];
  end

  // Request history and pending state; both lost on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_prev_reg <= '0;
      pending_reg  <= '0;
    end else begin
      req_prev_reg <= med_req;
      pending_reg  <= pending_next;
    end
  end

  // Lowest set index wins; scanning downward leaves the smallest index last.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_MED - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign grant_valid = |pending_reg;
  assign pending     = pending_reg;

endmodule

// File: rtl/med_dispense_ctrl.sv
// Medicine dispense controller: serves queued dose requests one at a time,
// drives the motor for the selected medicine, waits for the mechanism's done
// pulse, then raises a patient alert until acknowledged or timed out.
// Reports missed doses (saturating count) and sticky motor-timeout faults.
// Optional build macro MED_DISPENSE_RETRY_EN: the first motor timeout of a
// request drops the motor for one cycle and re-drives; only a second timeout
// raises the fault.
module med_dispense_ctrl
  import med_dispense_ctrl_pkg::*;
#(
  parameter int MOTOR_TO = 16,
  parameter int ACK_TO   = 64,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MED-1:0] med_req,
  input  logic               motor_done,
  input  logic               ack_btn,
  input  logic               fault_clr,
  output logic [NUM_MED-1:0] motor_en,
  output logic               alert,
  output logic               busy,
  output logic [IDX_W-1:0]   cur_med,
  output logic [NUM_MED-1:0] pending,
  output logic [CNT_W-1:0]   missed_cnt,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_med
);

`ifdef MED_DISPENSE_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int TMR_W = $clog2((ACK_TO > MOTOR_TO) ? ACK_TO : MOTOR_TO);
  localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_TO - 1);
  localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TO - 1);

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [IDX_W-1:0]   cur_med_reg, cur_med_next;
  logic               fault_reg, fault_next;
  logic [IDX_W-1:0]   fault_med_reg, fault_med_next;
  logic [CNT_W-1:0]   missed_reg, missed_next;
  logic               retry_reg, retry_next;
  logic               gap_reg, gap_next;
  logic               grant_clr;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               fault_set;

  med_req_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .med_req     (med_req),
    .grant_clr   (grant_clr),
    .pending     (pending),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Controller state register; reset aborts any service in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      cur_med_reg   <= '0;
      fault_reg     <= 1'b0;
      fault_med_reg <= '0;
      missed_reg    <= '0;
      retry_reg     <= 1'b0;
      gap_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      cur_med_reg   <= cur_med_next;
      fault_reg     <= fault_next;
      fault_med_reg <= fault_med_next;
      missed_reg    <= missed_next;
      retry_reg     <= retry_next;
      gap_reg       <= gap_next;
    end
  end

  // Next-state logic: dispatch, motor supervision, alert supervision, fault flag.
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    cur_med_next   = cur_med_reg;
    fault_med_next = fault_med_reg;
    missed_next    = missed_reg;
    retry_next     = retry_reg;
    gap_next       = gap_reg;
    grant_clr      = 1'b0;
    fault_set      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next   = DRIVE;
          cur_med_next = grant_idx;
          grant_clr    = 1'b1;
          timer_next   = '0;
          retry_next   = 1'b0;
          gap_next     = 1'b0;
        end
      end

      DRIVE: begin
        if (motor_done) begin
          // Completion beats a coincident timeout.
          state_next = WAIT_ACK;
          timer_next = '0;
          retry_next = 1'b0;
          gap_next   = 1'b0;
        end else if (gap_reg) begin
          // One idle cycle between the failed attempt and the re-drive.
          gap_next = 1'b0;
        end else if (timer_reg == MOTOR_LAST) begin
          timer_next = '0;
          if (RETRY_EN && !retry_reg) begin
            retry_next = 1'b1;
            gap_next   = 1'b1;
          end else begin
            fault_set      = 1'b1;
            fault_med_next = cur_med_reg;
            state_next     = IDLE;
            retry_next     = 1'b0;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      WAIT_ACK: begin
        if (ack_btn) begin
          state_next = IDLE;
        end else if (timer_reg == ACK_LAST) begin
          if (missed_reg != {CNT_W{1'b1}}) begin
            missed_next = missed_reg + 1'b1;
          end
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A new fault outranks a coincident clear.
    if (fault_set) begin
      fault_next = 1'b1;
    end else if (fault_clr) begin
      fault_next = 1'b0;
    end else begin
      fault_next = fault_reg;
    end
  end

  // Outputs decoded from registered state so reset drops them immediately.
  always_comb begin
    motor_en = '0;
    if (state_reg == DRIVE && !gap_reg) begin
      motor_en = onehot(cur_med_reg);
    end
  end

  assign alert      = (state_reg == WAIT_ACK);
  assign busy       = (state_reg != IDLE);
  assign cur_med    = cur_med_reg;
  assign missed_cnt = missed_reg;
  assign fault      = fault_reg;
  assign fault_med  = fault_med_reg;

endmodule

// File: tb/tb_med_dispense_ctrl.sv
// Bench for med_dispense_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_med_dispense_ctrl;

  localparam int MOTOR_TO = 16;
  localparam int ACK_TO   = 64;
`ifdef MED_DISPENSE_RETRY_EN
  localparam bit RETRY      = 1'b1;
  localparam int DRIVE_LIM  = 2 * MOTOR_TO + 1;
  localparam int DRIVE_HIGH = 2 * MOTOR_TO;
`else
  localparam bit RETRY      = 1'b0;
  localparam int DRIVE_LIM  = MOTOR_TO;
  localparam int DRIVE_HIGH = MOTOR_TO;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] med_req;
  logic       motor_done, ack_btn, fault_clr;
  logic [3:0] motor_en;
  logic       alert, busy;
  logic [1:0] cur_med;
  logic [3:0] pending;
  logic [7:0] missed_cnt;
  logic       fault;
  logic [1:0] fault_med;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 = waiting, 1 = motor, 2 = alert
  int         m_phase, m_elapsed, m_cur, m_fault_med, m_missed;
  logic [3:0] m_pend, m_prev;
  bit         m_fault;
  bit         prev_busy;
  int         order[$];

  med_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .med_req    (med_req),
    .motor_done (motor_done),
    .ack_btn    (ack_btn),
    .fault_clr  (fault_clr),
    .motor_en   (motor_en),
    .alert      (alert),
    .busy       (busy),
    .cur_med    (cur_med),
    .pending    (pending),
    .missed_cnt (missed_cnt),
    .fault      (fault),
    .fault_med  (fault_med)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_cur = 0; m_fault_med = 0; m_missed = 0;
    m_pend = '0; m_prev = '0; m_fault = 1'b0; prev_busy = 1'b0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic model_step();
    logic [3:0] rise;
    bit         new_fault;
    if (!rst) begin
      model_reset();
      return;
    end
    rise      = med_req & ~m_prev;
    m_prev    = med_req;
    new_fault = 1'b0;
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        m_cur = lowest(m_pend);
        m_pend[m_cur] = 1'b0;
        m_phase = 1;
        m_elapsed = 0;
      end
    end else if (m_phase == 1) begin
      if (motor_done) begin
        m_phase = 2; m_elapsed = 0;
      end else if (m_elapsed == DRIVE_LIM - 1) begin
        new_fault = 1'b1; m_fault_med = m_cur; m_phase = 0;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (ack_btn) begin
        m_phase = 0;
      end else if (m_elapsed == ACK_TO - 1) begin
        if (m_missed < 255) m_missed++;
        m_phase = 0;
      end else begin
        m_elapsed++;
      end
    end
    m_pend = m_pend | rise;
    if (new_fault) m_fault = 1'b1;
    else if (fault_clr) m_fault = 1'b0;
  endtask

  function automatic logic [22:0] model_vec();
    logic [3:0] me;
    me = '0;
    if (m_phase == 1 && !(RETRY && m_elapsed == MOTOR_TO)) me[m_cur] = 1'b1;
    return {me, 1'(m_phase == 2), 1'(m_phase != 0), 2'(m_cur), m_pend,
            8'(m_missed), m_fault, 2'(m_fault_med)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", {motor_en, alert, busy, cur_med, pending, missed_cnt, fault, fault_med},
          model_vec());
    if (busy && !prev_busy) begin
      order.push_back(int'(cur_med));
      $display("txn: dispatch med=%0d t=%0t", cur_med, $time);
    end
    prev_busy = busy;
  endtask

  task automatic pulse_done();
    motor_done = 1'b1; tick(); motor_done = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_btn = 1'b1; tick(); ack_btn = 1'b0;
  endtask

  task automatic request(input logic [3:0] v);
    med_req = v; tick(); med_req = '0;
  endtask

  task automatic do_miss();
    request(4'b0001);
    tick();
    pulse_done();
    repeat (ACK_TO) tick();
  endtask

  initial begin
    int n, guard;
    bit saw_alert;

    rst = 1'b0; med_req = '0; motor_done = 1'b0; ack_btn = 1'b0; fault_clr = 1'b0;
    model_reset();
    tick(); tick();
    check("reset_motor_en", motor_en, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    tick();

    // single request held for three cycles
    order.delete();
    med_req = 4'b0010; tick();
    check("single_pending", pending, 4'b0010);
    tick();
    check("single_motor_en", motor_en, 4'b0010);
    tick(); med_req = '0;
    repeat (3) tick();
    pulse_done();
    n = 0;
    repeat (9) begin if (alert) n++; tick(); end
    ack_btn = 1'b1; if (alert) n++; tick(); ack_btn = 1'b0;
    check("single_alert_cycles", n, 10);
    check("single_missed", missed_cnt, 0);
    repeat (3) tick();
    check("single_dispatches", order.size(), 1);

    // simultaneous requests served lowest first with one idle cycle between
    order.delete();
    request(4'b1011);
    repeat (3) begin
      tick();
      pulse_done();
      pulse_ack();
    end
    tick();
    check("multi_count", order.size(), 3);
    if (order.size() == 3) begin
      check("multi_first", order[0], 0);
      check("multi_second", order[1], 1);
      check("multi_third", order[2], 3);
    end
    check("multi_pending", pending, 0);

    // acknowledge timeout
    request(4'b0001);
    tick();
    pulse_done();
    n = 0;
    while (alert && n < 200) begin n++; tick(); end
    check("ack_to_alert_cycles", n, ACK_TO);
    check("ack_to_missed", missed_cnt, 1);
    repeat (254) do_miss();
    check("missed_at_max", missed_cnt, 255);
    do_miss();
    check("missed_saturated", missed_cnt, 255);

    // motor timeout
    request(4'b0100);
    tick();
    n = 0; guard = 0; saw_alert = 1'b0;
    while (busy && guard < 200) begin
      if (motor_en != 0) n++;
      if (alert) saw_alert = 1'b1;
      guard++;
      tick();
    end
    check("motor_to_drive_cycles", n, DRIVE_HIGH);
    check("motor_to_fault", fault, 1);
    check("motor_to_fault_med", fault_med, 2);
    check("motor_to_no_alert", saw_alert, 0);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("fault_cleared", fault, 0);

    // re-request of the medicine in service
    order.delete();
    request(4'b0100);
    tick();
    pulse_done();
    request(4'b0100);
    check("rereq_pending", pending, 4'b0100);
    pulse_ack();
    tick();
    check("rereq_served_again", (order.size() == 2) ? order[1] : -1, 2);
    pulse_done();
    pulse_ack();
    tick();

    // motor_done arriving in the timeout cycle
    request(4'b0010);
    tick();
    repeat (DRIVE_LIM - 1) tick();
    pulse_done();
    check("done_race_alert", alert, 1);
    check("done_race_fault", fault, 0);
    pulse_ack();
    tick();

    // fault_clr coincident with a new fault
    request(4'b1000);
    tick();
    repeat (DRIVE_LIM - 1) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("clr_race_fault", fault, 1);
    check("clr_race_fault_med", fault_med, 3);
    tick();

    // reset in the middle of DRIVE
    request(4'b1001);
    tick();
    check("pre_reset_motor_en", motor_en, 4'b0001);
    #3 rst = 1'b0;
    #1;
    check("async_motor_en", motor_en, 0);
    check("async_pending", pending, 0);
    check("async_missed", missed_cnt, 0);
    check("async_fault", fault, 0);
    model_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    check("post_reset_busy", busy, 0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) med_req[b] = ~med_req[b];
      motor_done = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      ack_btn    = ($urandom_range(0, 7) == 0);
      fault_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
